axi_lite_cfg_master: RTL
========================

Name: axi_lite_cfg_master

Overview:
- AXI4-Lite initiator that turns a simple one-at-a-time command interface into single-beat AXI4-Lite write and read transactions.
- It drives the 9-bit-address / 32-bit-data configuration register port of dfr_core_top from on-chip logic (a sequencer or host bridge), in place of an external processor.
- Exactly one transaction is outstanding at a time.
- The block reports the response code, read data and running statistics back to the requester.

Parameters:
- C_M_AXI_ADDR_WIDTH, 9, AXI address width; also the width of cmd_addr.
- C_M_AXI_DATA_WIDTH, 32, AXI data width; also the width of cmd_wdata, rsp_rdata and M_AXI_RDATA.
- CNT_WIDTH, 16, width of the txn_count and err_count statistics counters.

Ports:
- M_AXI_ACLK  in  1  single clock; all logic is on its rising edge.
- M_AXI_ARESETN  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block is idle and can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_M_AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  C_M_AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  C_M_AXI_DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  requester accepts the response.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  C_M_AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the transaction.
- M_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  standard AXI4-Lite master directions and widths.
- txn_count  out  CNT_WIDTH  completed transactions; wraps.
- err_count  out  CNT_WIDTH  transactions with a non-OKAY response; saturates.

Behaviour:
- Reset (asynchronous, immediate):
  - State returns to IDLE.
  - All of AWVALID, WVALID, ARVALID, BREADY, RREADY and rsp_valid go to 0.
  - All address, data, strobe and rsp_* registers go to 0; both counters go to 0.
  - cmd_ready = 1 once reset is released.
  - Reset asserted mid-transaction abandons that transaction with no response.
- All outputs are registered.
- States: IDLE, WR, WAIT_B, RD, WAIT_R, RSP.
- IDLE:
  - cmd_ready = 1.
  - A handshake (cmd_valid & cmd_ready) latches addr, wdata and wstrb.
  - Write → WR, with AWVALID = WVALID = 1 in the next cycle.
  - Read → RD, with ARVALID = 1 in the next cycle.
- WR:
  - AW and W channels are tracked independently with aw_done and w_done flags.
  - Each VALID is held, with stable payload, until its READY is sampled high, then drops in the following cycle.
  - If AWREADY and WREADY arrive in the same cycle, both complete.
  - When both channels are done → WAIT_B with BREADY = 1.
  - BREADY is never asserted before both channels complete.
- WAIT_B: on BVALID, latch BRESP, drop BREADY, set rsp_write = 1 and rsp_rdata = 0 → RSP.
- RD: ARVALID is held until ARREADY is sampled, then → WAIT_R with RREADY = 1.
- WAIT_R: on RVALID, latch RDATA and RRESP, drop RREADY, set rsp_write = 0 → RSP.
- RSP:
  - rsp_valid = 1, with rsp_* held stable until rsp_ready is sampled; then → IDLE.
  - cmd_ready = 1 in the cycle after the rsp_ready handshake.
  - txn_count increments once per transaction, on the rsp_ready handshake.
  - err_count increments on the same handshake when rsp_resp != 2'b00, and holds at its all-ones value.
- cmd_ready = 0 in every state other than IDLE; a cmd_valid seen outside IDLE is ignored.
- A VALID is never deasserted before its handshake; there is no timeout.
- Minimum write latency with all slave READYs and BVALID tied high: cmd accepted at cycle N, AW/W handshake at N+1, B at N+2, rsp_valid at N+3.
- Minimum read latency: AR handshake at N+1, R at N+2, rsp_valid at N+3.

Test Plan:
- Write to dfr_core_top: addr 0x000, data 0xDEADBEEF, wstrb 0xF → exactly one AW and one W beat with those values; rsp_resp = 0; txn_count = 1; a subsequent read of addr 0x000 returns rsp_rdata = 0xDEADBEEF.
- Skewed handshake: slave-model WREADY delayed 5 cycles after AWREADY → AWVALID drops after its handshake; WVALID is held 5 more cycles with stable 0x12345678; BREADY rises only after the W handshake.
- Simultaneous ready: AWREADY and WREADY are high in the same cycle → both VALIDs drop together the next cycle; WAIT_B is entered.
- Error response: slave model returns RRESP = 2'b10 on a read of addr 0x1FC → rsp_resp = 2'b10; err_count = 1; txn_count increments. Forcing err_count to 0xFFFF and issuing another error leaves it at 0xFFFF.
- Back-pressure: rsp_ready held low for 10 cycles → rsp_valid and rsp_* stay stable; cmd_ready stays 0; a second cmd_valid is not accepted until one cycle after the rsp_ready handshake.
- Reset mid-write: M_AXI_ARESETN pulled low while AWVALID = 1 → AWVALID, WVALID, BREADY and rsp_valid fall immediately; counters read 0; cmd_ready = 1 after release.

Source files
------------

// File: rtl/axi_lite_cfg_master_if.sv
// AXI4-Lite bus bundle between the configuration master and its register slave.
// Master modport drives the request side; slave modport drives readies and responses.
interface axi_lite_cfg_master_if #(
    parameter int unsigned AddrWidth = 9,
    parameter int unsigned DataWidth = 32
);
    logic [AddrWidth-1:0]   awaddr;
    logic                   awvalid;
    logic                   awready;
    logic [DataWidth-1:0]   wdata;
    logic [DataWidth/8-1:0] wstrb;
    logic                   wvalid;
    logic                   wready;
    logic [1:0]             bresp;
    logic                   bvalid;
    logic                   bready;
    logic [AddrWidth-1:0]   araddr;
    logic                   arvalid;
    logic                   arready;
    logic [DataWidth-1:0]   rdata;
    logic [1:0]             rresp;
    logic                   rvalid;
    logic                   rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_cfg_master.sv
// Single-outstanding AXI4-Lite initiator: turns one command into one write or read
// transaction and returns the response code, read data and running statistics.
module axi_lite_cfg_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 9,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH          = 16
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    axi_lite_cfg_master_if.master           m_axi,
    output logic [CNT_WIDTH-1:0]            txn_count,
    output logic [CNT_WIDTH-1:0]            err_count
);

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWaitB,
        StRd,
        StWaitR,
        StRsp
    } state_e;

    state_e state_q;
    logic   aw_done_q;
    logic   w_done_q;

    logic aw_hs;
    logic w_hs;
    logic aw_fin;
    logic w_fin;

    assign aw_hs  = m_axi.awvalid & m_axi.awready;
    assign w_hs   = m_axi.wvalid & m_axi.wready;
    // A channel counts as finished if it completed earlier or completes this cycle.
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q       <= StIdle;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            cmd_ready     <= 1'b1;
            m_axi.awaddr  <= '0;
            m_axi.awvalid <= 1'b0;
            m_axi.wdata   <= '0;
            m_axi.wstrb   <= '0;
            m_axi.wvalid  <= 1'b0;
            m_axi.bready  <= 1'b0;
            m_axi.araddr  <= '0;
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= 2'b00;
            txn_count     <= '0;
            err_count     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready    <= 1'b0;
                        m_axi.awaddr <= cmd_addr;
                        m_axi.araddr <= cmd_addr;
                        m_axi.wdata  <= cmd_wdata;
                        m_axi.wstrb  <= cmd_wstrb;
                        aw_done_q    <= 1'b0;
                        w_done_q     <= 1'b0;
                        if (cmd_write) begin
                            m_axi.awvalid <= 1'b1;
                            m_axi.wvalid  <= 1'b1;
                            state_q       <= StWr;
                        end else begin
                            m_axi.arvalid <= 1'b1;
                            state_q       <= StRd;
                        end
                    end
                end

                StWr: begin
                    if (aw_hs) begin
                        m_axi.awvalid <= 1'b0;
                        aw_done_q     <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi.wvalid <= 1'b0;
                        w_done_q     <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        m_axi.bready <= 1'b1;
                        state_q      <= StWaitB;
                    end
                end

                StWaitB: begin
                    if (m_axi.bvalid) begin
                        m_axi.bready <= 1'b0;
                        rsp_resp     <= m_axi.bresp;
                        rsp_write    <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_valid    <= 1'b1;
                        state_q      <= StRsp;
                    end
                end

                StRd: begin
                    if (m_axi.arready) begin
                        m_axi.arvalid <= 1'b0;
                        m_axi.rready  <= 1'b1;
                        state_q       <= StWaitR;
                    end
                end

                StWaitR: begin
                    if (m_axi.rvalid) begin
                        m_axi.rready <= 1'b0;
                        rsp_rdata    <= m_axi.rdata;
                        rsp_resp     <= m_axi.rresp;
                        rsp_write    <= 1'b0;
                        rsp_valid    <= 1'b1;
                        state_q      <= StRsp;
                    end
                end

                StRsp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        txn_count <= txn_count + CNT_WIDTH'(1);
                        // Error count sticks at all-ones rather than wrapping.
                        if ((rsp_resp != 2'b00) && (err_count != {CNT_WIDTH{1'b1}})) begin
                            err_count <= err_count + CNT_WIDTH'(1);
                        end
                        state_q <= StIdle;
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
